// File: rtl/serial_frame_receiver.sv
// LSB-first serial frame receiver: start bit, N data bits, stop bit, paced by an
// external bit strobe. Good frames are offered on a valid/ready holding register.
module serial_frame_receiver #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         bit_en,
    input  logic         s_in,
    input  logic         p_ready,
    output logic [N-1:0] p_out,
    output logic         p_valid,
    output logic         busy,
    output logic         frame_err,
    output logic         overrun
);

    localparam int CNT_W = $clog2(N);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] STOP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     p_out_q, p_out_d;
    logic             p_valid_q, p_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        p_out_d     = p_out_q;
        // A pending word is consumed whenever the downstream is ready; a load below overrides this.
        p_valid_d   = p_valid_q & ~p_ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bit_en && !s_in) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (bit_en) begin
                    shift_d = {s_in, shift_q[N-1:1]};
                    if (cnt_q == CNT_W'(N - 1)) begin
                        cnt_d   = '0;
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_en) begin
                    state_d = IDLE;
                    if (!s_in) begin
                        frame_err_d = 1'b1;
                    end else if (!p_valid_q || p_ready) begin
                        p_out_d   = shift_q;
                        p_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            p_out_q     <= '0;
            p_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            p_out_q     <= p_out_d;
            p_valid_q   <= p_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign p_out     = p_out_q;
    assign p_valid   = p_valid_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Self-checking bench: directed frames plus randomized frames, compared every cycle
// against a frame-level model of the holding register and error pulses.
module tb_serial_frame_receiver;

    localparam int N = 4;
    localparam int K_NONE  = 0;
    localparam int K_START = 1;
    localparam int K_STOP  = 2;
    // ready modes: 0 never, 1 always, 2 random, 3 only on the stop-bit cycle
    localparam int R_LOW = 0, R_HIGH = 1, R_RAND = 2, R_STOP = 3;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         bit_en = 1'b0;
    logic         s_in = 1'b1;
    logic         p_ready = 1'b0;
    logic [N-1:0] p_out;
    logic         p_valid;
    logic         busy;
    logic         frame_err;
    logic         overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: the holding register and whether a frame is in flight.
    logic [N-1:0] m_out   = '0;
    logic         m_valid = 1'b0;
    logic         m_busy  = 1'b0;
    logic         m_err   = 1'b0;
    logic         m_ovr   = 1'b0;

    serial_frame_receiver #(.N(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bit_en    (bit_en),
        .s_in      (s_in),
        .p_ready   (p_ready),
        .p_out     (p_out),
        .p_valid   (p_valid),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("p_valid", p_valid, m_valid);
        if (m_valid) check("p_out", p_out, m_out);
        check("busy", busy, m_busy);
        check("frame_err", frame_err, m_err);
        check("overrun", overrun, m_ovr);
    endtask

    // One clock: drive inputs, predict the edge, compare after it (at the falling edge).
    task automatic cycle(input logic be, input logic s, input logic rdy,
                         input int kind, input logic [N-1:0] d);
        logic [N-1:0] n_out;
        logic n_valid, n_busy, n_err, n_ovr;
        bit_en  = be;
        s_in    = s;
        p_ready = rdy;
        n_out   = m_out;
        n_valid = m_valid && !rdy;
        n_busy  = m_busy;
        n_err   = 1'b0;
        n_ovr   = 1'b0;
        if (kind == K_START) n_busy = 1'b1;
        if (kind == K_STOP) begin
            n_busy = 1'b0;
            if (!s) n_err = 1'b1;
            else if (!m_valid || rdy) begin
                n_out   = d;
                n_valid = 1'b1;
            end else n_ovr = 1'b1;
        end
        @(posedge clk);
        m_out = n_out; m_valid = n_valid; m_busy = n_busy; m_err = n_err; m_ovr = n_ovr;
        @(negedge clk);
        check_all();
    endtask

    function automatic logic pick_rdy(input int mode, input bit at_stop);
        case (mode)
            R_LOW:   return 1'b0;
            R_HIGH:  return 1'b1;
            R_RAND:  return 1'($urandom_range(0, 1));
            default: return at_stop;
        endcase
    endfunction

    // Non-strobe cycles with a toggling line; these must be ignored by the receiver.
    task automatic gap_cycles(input int gap, input int mode);
        for (int g = 0; g < gap; g++)
            cycle(1'b0, 1'($urandom_range(0, 1)), pick_rdy(mode, 1'b0), K_NONE, '0);
    endtask

    task automatic send_frame(input logic [N-1:0] d, input logic stop, input int gap, input int mode);
        cycle(1'b1, 1'b0, pick_rdy(mode, 1'b0), K_START, '0);
        gap_cycles(gap, mode);
        for (int i = 0; i < N; i++) begin
            cycle(1'b1, d[i], pick_rdy(mode, 1'b0), K_NONE, '0);
            gap_cycles(gap, mode);
        end
        cycle(1'b1, stop, pick_rdy(mode, 1'b1), K_STOP, d);
    endtask

    task automatic model_reset();
        m_out = '0; m_valid = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        logic [N-1:0] d;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_p_out", p_out, 0);
        check("rst_p_valid", p_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic frame 0xA, strobe every cycle; count busy cycles
        busy_cnt = 0;
        cycle(1'b1, 1'b0, 1'b1, K_START, '0);
        busy_cnt += int'(busy);
        for (int i = 0; i < N; i++) begin
            cycle(1'b1, (i == 1 || i == 3), 1'b1, K_NONE, '0);
            busy_cnt += int'(busy);
        end
        cycle(1'b1, 1'b1, 1'b1, K_STOP, 4'hA);
        check("basic_p_out", p_out, 4'hA);
        check("basic_p_valid", p_valid, 1);
        cycle(1'b1, 1'b1, 1'b1, K_NONE, '0);
        check("basic_valid_drop", p_valid, 0);
        check("basic_busy_cycles", busy_cnt, 5);

        // Sparse strobe, every 3rd cycle with toggling line
        send_frame(4'hA, 1'b1, 2, R_LOW);
        check("sparse_p_out", p_out, 4'hA);
        cycle(1'b0, 1'b0, 1'b1, K_NONE, '0);

        // Framing error then immediate good frame
        send_frame(4'h5, 1'b0, 0, R_HIGH);
        check("ferr_pulse", frame_err, 1);
        check("ferr_no_valid", p_valid, 0);
        send_frame(4'h9, 1'b1, 0, R_HIGH);
        check("after_ferr_p_out", p_out, 4'h9);
        cycle(1'b1, 1'b1, 1'b1, K_NONE, '0);

        // Overrun: hold 0x3, drop 0x5
        send_frame(4'h3, 1'b1, 0, R_LOW);
        send_frame(4'h5, 1'b1, 0, R_LOW);
        check("ovr_pulse", overrun, 1);
        check("ovr_held", p_out, 4'h3);
        cycle(1'b1, 1'b1, 1'b0, K_NONE, '0);
        check("ovr_one_cycle", overrun, 0);
        cycle(1'b1, 1'b1, 1'b1, K_NONE, '0);
        check("ovr_drain", p_valid, 0);

        // Simultaneous accept and load
        send_frame(4'h3, 1'b1, 0, R_LOW);
        send_frame(4'hC, 1'b1, 0, R_STOP);
        check("simul_valid", p_valid, 1);
        check("simul_p_out", p_out, 4'hC);
        check("simul_no_ovr", overrun, 0);
        cycle(1'b1, 1'b1, 1'b1, K_NONE, '0);

        // Reset mid-frame, between clock edges
        send_frame(4'h7, 1'b1, 0, R_LOW);
        cycle(1'b1, 1'b0, 1'b0, K_START, '0);
        cycle(1'b1, 1'b0, 1'b0, K_NONE, '0);
        cycle(1'b1, 1'b1, 1'b0, K_NONE, '0);
        bit_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_p_out", p_out, 0);
        check("mid_rst_p_valid", p_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ferr", frame_err, 0);
        #1 reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        send_frame(4'h6, 1'b1, 0, R_HIGH);
        check("post_rst_p_out", p_out, 4'h6);

        // Randomized frames
        for (int f = 0; f < 200; f++) begin
            d = N'($urandom);
            send_frame(d, 1'(($urandom_range(0, 7)) != 0), $urandom_range(0, 2), R_RAND);
            for (int k = $urandom_range(0, 2); k > 0; k--)
                cycle(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), K_NONE, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
